// File: rtl/pio_input_conditioner_pkg.sv
// Shared register map, bus width and edge-select encoding for the PIO input conditioner.
package pio_cond_pkg;

    localparam int REG_W = 32;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
    localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_sel_e;

    // Per-bit sticky capture: a new set event beats a simultaneous write-1-to-clear.
    function automatic logic capture_next(input logic cur, input logic clr, input logic set);
        return (cur & ~clr) | set;
    endfunction

endpackage

// File: rtl/pio_input_conditioner_if.sv
// Register slave bus for the input conditioner: word address, strobes, data both ways.
interface pio_input_conditioner_if;
    import pio_cond_pkg::*;

    logic [1:0]       addr;
    logic             read;
    logic             write;
    logic [REG_W-1:0] wdata;
    logic [REG_W-1:0] rdata;

    modport master (
        output addr,
        output read,
        output write,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  read,
        input  write,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/pio_input_conditioner_debounce_ch.sv
// One input channel: 2-FF synchroniser, debounce counter, stable level and edge pulses.
// INIT is the raw pad value meaning "not pressed" (1 for an active-low input).
module debounce_ch #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic INIT            = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             norm;
    logic             stable_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Sync FFs carry the raw value and normalise after s2; resetting them to INIT
    // is equivalent to normalising first and resetting to not-pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= INIT;
            s2     <= INIT;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            cnt    <= cnt_next;
            stable <= stable_next;
        end
    end

    always_comb begin
        norm        = s2 ^ INIT;
        cnt_next    = '0;
        stable_next = stable;
        if (norm != stable) begin
            if (cnt == CNT_LAST) begin
                stable_next = norm;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    assign rise = ~rst & stable_next & ~stable;
    assign fall = ~rst & ~stable_next & stable;

endmodule

// File: rtl/pio_input_conditioner.sv
// N-channel button/switch conditioner with edge capture, interrupt masking and a 4-word register slave.
module pio_input_conditioner
    import pio_cond_pkg::*;
#(
    parameter int              N_CH            = 8,
    parameter int              DEBOUNCE_CYCLES = 50000,
    parameter logic [N_CH-1:0] ACTIVE_LOW      = N_CH'(8'hFF)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        raw_in,
    pio_input_conditioner_if.slave bus,
    output logic [N_CH-1:0]        level,
    output logic                   irq
);

    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  fall;
    logic [N_CH-1:0]  irq_mask;
    logic [N_CH-1:0]  edge_cap;
    logic [N_CH-1:0]  edge_sel;
    logic [N_CH-1:0]  cap_set;
    logic [N_CH-1:0]  w1c;
    logic [N_CH-1:0]  edge_cap_next;
    logic             wr_mask;
    logic             wr_sel;
    logic [REG_W-1:0] rd_mux;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INIT           (ACTIVE_LOW[i])
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_in[i]),
            .stable(level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    always_comb begin
        wr_mask       = bus.write && (bus.addr == ADDR_IRQ_MASK);
        wr_sel        = bus.write && (bus.addr == ADDR_EDGE_SEL);
        w1c           = (bus.write && (bus.addr == ADDR_EDGE_CAP)) ? bus.wdata[N_CH-1:0] : '0;
        cap_set       = '0;
        edge_cap_next = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cap_set[i]       = (edge_sel_e'(edge_sel[i]) == EDGE_FALL) ? fall[i] : rise[i];
            edge_cap_next[i] = capture_next(edge_cap[i], w1c[i], cap_set[i]);
        end
    end

    // Read mux looks at the registered values, so a same-cycle write is not visible yet.
    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_DATA:     rd_mux = REG_W'(level);
            ADDR_IRQ_MASK: rd_mux = REG_W'(irq_mask);
            ADDR_EDGE_CAP: rd_mux = REG_W'(edge_cap);
            ADDR_EDGE_SEL: rd_mux = REG_W'(edge_sel);
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_mask  <= '0;
            edge_cap  <= '0;
            edge_sel  <= '0;
            bus.rdata <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_mask) begin
                irq_mask <= bus.wdata[N_CH-1:0];
            end
            if (wr_sel) begin
                edge_sel <= bus.wdata[N_CH-1:0];
            end
            edge_cap <= edge_cap_next;
            if (bus.read) begin
                bus.rdata <= rd_mux;
            end
            irq <= |(edge_cap & irq_mask);
        end
    end

endmodule

// File: tb/tb_pio_input_conditioner.sv
// Directed bench for pio_input_conditioner with 4 channels, 4-cycle debounce, channels 0/1 active-low.
module tb_pio_input_conditioner;
    import pio_cond_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] raw_in;
    logic [N-1:0] level;
    logic         irq;
    logic [31:0]  rd;
    logic [31:0]  held;
    int           vectors     = 0;
    int           miscompares = 0;

    pio_input_conditioner_if bif ();

    pio_input_conditioner #(
        .N_CH           (N),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (4'b0011)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .raw_in(raw_in),
        .bus   (bif),
        .level (level),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        bif.addr  = a;
        bif.wdata = d;
        bif.write = 1'b1;
        tick();
        bif.write = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        bif.addr = a;
        bif.read = 1'b1;
        tick();
        bif.read = 1'b0;
        d = bif.rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw_in = 4'b0011;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (level !== 4'b0000) begin
            $display("FAIL reset_level: got %b expected 0000", level);
            miscompares++;
        end
        vectors++;
        if (irq !== 1'b0) begin
            $display("FAIL reset_irq: got %b expected 0", irq);
            miscompares++;
        end
        vectors++;
        if (bif.rdata !== 32'h0) begin
            $display("FAIL reset_rdata: got %h expected 0", bif.rdata);
            miscompares++;
        end
        for (int a = 0; a < 4; a++) begin
            reg_read(2'(a), rd);
            vectors++;
            if (rd !== 32'h0) begin
                $display("FAIL reset_reg%0d: got %h expected 0", a, rd);
                miscompares++;
            end
        end
        for (int k = 0; k < 8; k++) tick();
        reg_read(ADDR_EDGE_CAP, rd);
        vectors++;
        if (rd !== 32'h0 || level !== 4'b0000) begin
            $display("FAIL reset_no_capture: cap %h level %b expected 0 and 0000", rd, level);
            miscompares++;
        end
    endtask

    task automatic test_debounce_latency();
        raw_in[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++;
            if (level[2] !== (k == 6)) begin
                $display("FAIL latency_edge%0d: level[2] got %b expected %b", k, level[2], (k == 6));
                miscompares++;
            end
        end
        reg_read(ADDR_EDGE_CAP, rd);
        vectors++;
        if (rd !== 32'h4) begin
            $display("FAIL latency_cap: got %h expected 4", rd);
            miscompares++;
        end
        raw_in[2] = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        reg_write(ADDR_EDGE_CAP, 32'h4);
        reg_read(ADDR_EDGE_CAP, rd);
        vectors++;
        if (rd !== 32'h0 || level !== 4'b0000) begin
            $display("FAIL latency_clear: cap %h level %b expected 0 and 0000", rd, level);
            miscompares++;
        end
    endtask

    task automatic test_glitch();
        raw_in[0] = 1'b0;
        tick();
        tick();
        tick();
        raw_in[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if (level[0] !== 1'b0) begin
                $display("FAIL glitch_level%0d: got %b expected 0", k, level[0]);
                miscompares++;
            end
        end
        reg_read(ADDR_EDGE_CAP, rd);
        vectors++;
        if (rd !== 32'h0) begin
            $display("FAIL glitch_cap: got %h expected 0", rd);
            miscompares++;
        end
        raw_in[0] = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        vectors++;
        if (level[0] !== 1'b1) begin
            $display("FAIL glitch_press: level[0] got %b expected 1", level[0]);
            miscompares++;
        end
        reg_read(ADDR_EDGE_CAP, rd);
        vectors++;
        if (rd !== 32'h1) begin
            $display("FAIL glitch_press_cap: got %h expected 1", rd);
            miscompares++;
        end
        raw_in[0] = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        reg_write(ADDR_EDGE_CAP, 32'h1);
    endtask

    task automatic test_irq();
        reg_write(ADDR_IRQ_MASK, 32'h4);
        raw_in[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++;
            if (irq !== 1'b0) begin
                $display("FAIL irq_early%0d: got %b expected 0", k, irq);
                miscompares++;
            end
        end
        vectors++;
        if (level[2] !== 1'b1) begin
            $display("FAIL irq_level: got %b expected 1", level[2]);
            miscompares++;
        end
        tick();
        vectors++;
        if (irq !== 1'b1) begin
            $display("FAIL irq_assert: got %b expected 1", irq);
            miscompares++;
        end
        reg_write(ADDR_EDGE_CAP, 32'h4);
        vectors++;
        if (irq !== 1'b1) begin
            $display("FAIL irq_hold_after_w1c: got %b expected 1", irq);
            miscompares++;
        end
        tick();
        vectors++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_deassert: got %b expected 0", irq);
            miscompares++;
        end
        raw_in[2] = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        reg_read(ADDR_EDGE_CAP, rd);
        vectors++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            $display("FAIL irq_release: cap %h irq %b expected 0 and 0", rd, irq);
            miscompares++;
        end
    endtask

    task automatic test_falling_edge();
        reg_write(ADDR_EDGE_SEL, 32'h8);
        raw_in[3] = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        reg_read(ADDR_EDGE_CAP, rd);
        vectors++;
        if (rd !== 32'h0 || level[3] !== 1'b1) begin
            $display("FAIL fall_on_press: cap %h level[3] %b expected 0 and 1", rd, level[3]);
            miscompares++;
        end
        raw_in[3] = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        vectors++;
        if (level[3] !== 1'b1) begin
            $display("FAIL fall_level_early: got %b expected 1", level[3]);
            miscompares++;
        end
        tick();
        vectors++;
        if (level[3] !== 1'b0) begin
            $display("FAIL fall_level: got %b expected 0", level[3]);
            miscompares++;
        end
        reg_read(ADDR_EDGE_CAP, rd);
        vectors++;
        if (rd !== 32'h8) begin
            $display("FAIL fall_cap: got %h expected 8", rd);
            miscompares++;
        end
        vectors++;
        if (irq !== 1'b0) begin
            $display("FAIL fall_irq_masked: got %b expected 0", irq);
            miscompares++;
        end
        reg_read(ADDR_EDGE_SEL, rd);
        vectors++;
        if (rd !== 32'h8) begin
            $display("FAIL fall_sel_readback: got %h expected 8", rd);
            miscompares++;
        end
        reg_write(ADDR_EDGE_CAP, 32'h8);
        reg_write(ADDR_EDGE_SEL, 32'h0);
        tick();
        reg_read(ADDR_EDGE_CAP, rd);
        vectors++;
        if (rd !== 32'h0) begin
            $display("FAIL sel_write_no_capture: got %h expected 0", rd);
            miscompares++;
        end
    endtask

    task automatic test_set_clear_race();
        raw_in[1] = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        reg_write(ADDR_EDGE_CAP, 32'h2);
        vectors++;
        if (level[1] !== 1'b1) begin
            $display("FAIL race_level: got %b expected 1", level[1]);
            miscompares++;
        end
        reg_read(ADDR_EDGE_CAP, rd);
        vectors++;
        if (rd !== 32'h2) begin
            $display("FAIL race_set_wins: got %h expected 2", rd);
            miscompares++;
        end
        reg_write(ADDR_EDGE_CAP, 32'h2);
        reg_read(ADDR_EDGE_CAP, rd);
        vectors++;
        if (rd !== 32'h0) begin
            $display("FAIL race_clear_after: got %h expected 0", rd);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        bif.addr  = ADDR_IRQ_MASK;
        bif.wdata = 32'hA;
        bif.read  = 1'b1;
        bif.write = 1'b1;
        tick();
        bif.read  = 1'b0;
        bif.write = 1'b0;
        vectors++;
        if (bif.rdata !== 32'h4) begin
            $display("FAIL rw_prewrite: got %h expected 4", bif.rdata);
            miscompares++;
        end
        reg_read(ADDR_IRQ_MASK, rd);
        vectors++;
        if (rd !== 32'hA) begin
            $display("FAIL rw_postwrite: got %h expected a", rd);
            miscompares++;
        end
        reg_write(ADDR_IRQ_MASK, 32'hFFFF_FFFF);
        reg_read(ADDR_IRQ_MASK, rd);
        vectors++;
        if (rd !== 32'hF) begin
            $display("FAIL upper_bits_zero: got %h expected f", rd);
            miscompares++;
        end
        reg_write(ADDR_DATA, 32'hFFFF_FFFF);
        reg_read(ADDR_DATA, rd);
        vectors++;
        if (rd !== 32'h2) begin
            $display("FAIL data_ro: got %h expected 2", rd);
            miscompares++;
        end
        held = bif.rdata;
        bif.addr = ADDR_IRQ_MASK;
        tick();
        tick();
        tick();
        vectors++;
        if (bif.rdata !== 32'h2) begin
            $display("FAIL rdata_hold: got %h expected 2 (was %h)", bif.rdata, held);
            miscompares++;
        end
        raw_in[1] = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        reg_write(ADDR_IRQ_MASK, 32'h0);
    endtask

    task automatic test_reset_mid_debounce();
        reg_write(ADDR_IRQ_MASK, 32'h4);
        raw_in[2] = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++;
            if (level[2] !== (k == 6)) begin
                $display("FAIL rst_mid_edge%0d: level[2] got %b expected %b", k, level[2], (k == 6));
                miscompares++;
            end
        end
        reg_read(ADDR_EDGE_CAP, rd);
        vectors++;
        if (rd !== 32'h4) begin
            $display("FAIL rst_mid_cap: got %h expected 4", rd);
            miscompares++;
        end
        reg_read(ADDR_IRQ_MASK, rd);
        vectors++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            $display("FAIL rst_mid_mask: mask %h irq %b expected 0 and 0", rd, irq);
            miscompares++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        raw_in    = 4'b0011;
        bif.addr  = '0;
        bif.read  = 1'b0;
        bif.write = 1'b0;
        bif.wdata = '0;
        test_reset();
        test_debounce_latency();
        test_glitch();
        test_irq();
        test_falling_edge();
        test_set_clear_race();
        test_back_to_back();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
